// File: rtl/ex_shift_seq_if.sv
// EX-stage <-> shift sequencer handshake: start/annul/operands towards the sequencer,
// stall request, ready and result back to EX.
interface ex_shift_seq_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic              annul_i;
  logic [7:0]        aluop_i;
  logic [4:0]        shamt_i;
  logic [DATA_W-1:0] data_i;
  logic              stallreq_o;
  logic              ready_o;
  logic [DATA_W-1:0] result_o;

  modport master (
    output start_i, annul_i, aluop_i, shamt_i, data_i,
    input  stallreq_o, ready_o, result_o
  );

  modport slave (
    input  start_i, annul_i, aluop_i, shamt_i, data_i,
    output stallreq_o, ready_o, result_o
  );
endinterface

// File: rtl/ex_shift_seq.sv
// Multi-cycle SLL/SRL/SRA: up to STEP bits per BUSY cycle, result ceil(shamt/STEP)+1 cycles after accept.
// Stalls EX until DONE; result held while start_i stays high, annul_i drops the operation at once.
module ex_shift_seq #(
  parameter int STEP   = 4,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  ex_shift_seq_if.slave bus
);

  localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;
  localparam logic [4:0] STEP_K     = 5'(STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL,
    OP_SRL,
    OP_SRA
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [4:0]        rem_q, rem_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  op_e               dec_op;
  logic              dec_legal;
  logic [4:0]        k;
  logic              accept;

  always_comb begin
    dec_op    = OP_SLL;
    dec_legal = 1'b1;
    case (bus.aluop_i)
      EXE_SLL_OP: dec_op = OP_SLL;
      EXE_SRL_OP: dec_op = OP_SRL;
      EXE_SRA_OP: dec_op = OP_SRA;
      default:    dec_legal = 1'b0;
    endcase
  end

  assign accept = bus.start_i && !bus.annul_i;
  assign k      = (rem_q < STEP_K) ? rem_q : STEP_K;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    acc_d   = acc_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = dec_op;
          rem_d = bus.shamt_i;
          // An illegal op completes immediately with a zero result.
          acc_d = dec_legal ? bus.data_i : '0;
          if (!dec_legal || (bus.shamt_i == 5'd0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        case (op_q)
          OP_SLL:  acc_d = acc_q << k;
          OP_SRL:  acc_d = acc_q >> k;
          OP_SRA:  acc_d = $unsigned($signed(acc_q) >>> k);
          default: acc_d = '0;
        endcase
        rem_d = rem_q - k;
        if (rem_q == k) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Hold the result until EX has dropped start_i, so one request runs once.
        if (!bus.start_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (bus.annul_i) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_SLL;
      rem_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.ready_o    = (state_q == S_DONE);
  assign bus.result_o   = (state_q == S_DONE) ? acc_q : '0;
  assign bus.stallreq_o = !rst && (((state_q == S_IDLE) && accept) || (state_q == S_BUSY));

endmodule

// File: tb/tb_ex_shift_seq.sv
// Drives three sequencers (STEP = 1, 4, 16) with identical stimulus and checks each against
// a plain-arithmetic shifter and latency model, cycle by cycle.
module tb_ex_shift_seq;

  localparam logic [7:0] SLL = 8'b0111_1100;
  localparam logic [7:0] SRL = 8'b0000_0010;
  localparam logic [7:0] SRA = 8'b0000_0011;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, annul;
  logic [7:0]  aluop;
  logic [4:0]  shamt;
  logic [31:0] data;

  always #5 clk = ~clk;

  ex_shift_seq_if #(.DATA_W(32)) bus1 ();
  ex_shift_seq_if #(.DATA_W(32)) bus4 ();
  ex_shift_seq_if #(.DATA_W(32)) bus16 ();

  assign bus1.start_i  = start;  assign bus1.annul_i  = annul;  assign bus1.aluop_i  = aluop;
  assign bus1.shamt_i  = shamt;  assign bus1.data_i   = data;
  assign bus4.start_i  = start;  assign bus4.annul_i  = annul;  assign bus4.aluop_i  = aluop;
  assign bus4.shamt_i  = shamt;  assign bus4.data_i   = data;
  assign bus16.start_i = start;  assign bus16.annul_i = annul;  assign bus16.aluop_i = aluop;
  assign bus16.shamt_i = shamt;  assign bus16.data_i  = data;

  ex_shift_seq #(.STEP(1),  .DATA_W(32)) dut1  (.clk(clk), .rst(rst), .bus(bus1));
  ex_shift_seq #(.STEP(4),  .DATA_W(32)) dut4  (.clk(clk), .rst(rst), .bus(bus4));
  ex_shift_seq #(.STEP(16), .DATA_W(32)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  logic [2:0]  rdy, stl;
  logic [31:0] res [3];
  assign rdy    = {bus16.ready_o, bus4.ready_o, bus1.ready_o};
  assign stl    = {bus16.stallreq_o, bus4.stallreq_o, bus1.stallreq_o};
  assign res[0] = bus1.result_o;
  assign res[1] = bus4.result_o;
  assign res[2] = bus16.result_o;

  int errors = 0;
  int checks = 0;

  function automatic int step_of(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  function automatic bit is_legal(input logic [7:0] op);
    return (op == SLL) || (op == SRL) || (op == SRA);
  endfunction

  function automatic logic [31:0] ref_shift(input logic [7:0] op, input int sh, input logic [31:0] d);
    logic signed [31:0] sd;
    sd = d;
    if (op == SLL) return d << sh;
    if (op == SRL) return d >> sh;
    if (op == SRA) return $unsigned(sd >>> sh);
    return 32'h0;
  endfunction

  function automatic int ref_lat(input logic [7:0] op, input int sh, input int step);
    if (!is_legal(op)) return 1;
    return (sh + step - 1) / step + 1;
  endfunction

  // Idle-state check on all three instances.
  task automatic check_idle(input string name);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy[i] !== 1'b0 || stl[i] !== 1'b0 || res[i] !== 32'h0) begin
        errors++;
        $display("FAIL %s idle step=%0d got ready=%b stall=%b result=%h exp 0/0/00000000",
                 name, step_of(i), rdy[i], stl[i], res[i]);
      end
    end
  endtask

  // One operation from the IDLE negedge; abort_at>0 aborts after sample abort_at (annul or reset).
  task automatic run_op(input string name, input logic [7:0] op, input logic [4:0] sh,
                        input logic [31:0] d, input int hold, input int abort_at,
                        input bit use_rst, output int obs_lat, output logic [31:0] obs_res);
    int          lat [3];
    int          last;
    logic [31:0] exp_res;
    logic        exp_r;
    bit          aborted, abort_pend;
    exp_res    = ref_shift(op, int'(sh), d);
    last       = 0;
    for (int i = 0; i < 3; i++) begin
      lat[i] = ref_lat(op, int'(sh), step_of(i));
      if (lat[i] > last) last = lat[i];
    end
    last = last + hold;
    if (abort_at > 0 && last < abort_at + 3) last = abort_at + 3;
    aborted    = 0;
    abort_pend = 0;
    obs_lat    = -1;
    obs_res    = 32'h0;

    start = 1'b1; annul = 1'b0; aluop = op; shamt = sh; data = d;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stl[i] !== 1'b1) begin
        errors++;
        $display("FAIL %s accept_stall step=%0d got=%b exp=1", name, step_of(i), stl[i]);
      end
    end
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (abort_pend) aborted = 1;
      for (int i = 0; i < 3; i++) begin
        exp_r = !aborted && (c >= lat[i]);
        checks++;
        if (rdy[i] !== exp_r) begin
          errors++;
          $display("FAIL %s ready step=%0d cyc=%0d got=%b exp=%b", name, step_of(i), c, rdy[i], exp_r);
        end
        checks++;
        if (stl[i] !== (!aborted && !exp_r)) begin
          errors++;
          $display("FAIL %s stall step=%0d cyc=%0d got=%b exp=%b", name, step_of(i), c, stl[i],
                   (!aborted && !exp_r));
        end
        checks++;
        if (res[i] !== (exp_r ? exp_res : 32'h0)) begin
          errors++;
          $display("FAIL %s result step=%0d cyc=%0d got=%h exp=%h", name, step_of(i), c, res[i],
                   (exp_r ? exp_res : 32'h0));
        end
      end
      if (obs_lat < 0 && rdy[1] === 1'b1) begin
        obs_lat = c;
        obs_res = res[1];
      end
      // Operands wander after accept; only latched values may matter.
      aluop = 8'($urandom); shamt = 5'($urandom); data = $urandom;
      if (aborted && !use_rst) annul = 1'b0;
      if (c == abort_at) begin
        abort_pend = 1;
        if (use_rst) begin
          rst = 1'b1;
          #1;
          for (int i = 0; i < 3; i++) begin
            checks++;
            if (stl[i] !== 1'b0) begin
              errors++;
              $display("FAIL %s rst_stall step=%0d got=%b exp=0", name, step_of(i), stl[i]);
            end
          end
        end else begin
          annul = 1'b1;
          start = 1'b0;
        end
      end
    end
    rst = 1'b0; start = 1'b0; annul = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle(name);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; annul = 1'b0; aluop = SLL; shamt = 5'd5; data = $urandom;
    repeat (3) begin
      @(negedge clk);
      check_idle("reset");
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_sll();
    int l; logic [31:0] r;
    run_op("sll4", SLL, 5'd4, 32'h0000_00F1, 0, 0, 0, l, r);
    checks++;
    if (l !== 2 || r !== 32'h0000_0F10) begin
      errors++;
      $display("FAIL sll4_const got lat=%0d res=%h exp lat=2 res=00000f10", l, r);
    end
  endtask

  task automatic test_sra_srl();
    int l; logic [31:0] r;
    run_op("sra31", SRA, 5'd31, 32'h8000_0000, 0, 0, 0, l, r);
    checks++;
    if (l !== 9 || r !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sra31_const got lat=%0d res=%h exp lat=9 res=ffffffff", l, r);
    end
    run_op("srl31", SRL, 5'd31, 32'h8000_0000, 0, 0, 0, l, r);
    checks++;
    if (l !== 9 || r !== 32'h0000_0001) begin
      errors++;
      $display("FAIL srl31_const got lat=%0d res=%h exp lat=9 res=00000001", l, r);
    end
  endtask

  task automatic test_zero_illegal();
    int l; logic [31:0] r;
    run_op("zero", SLL, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, l, r);
    checks++;
    if (l !== 1 || r !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL zero_const got lat=%0d res=%h exp lat=1 res=deadbeef", l, r);
    end
    run_op("illegal", 8'h55, 5'd7, $urandom, 0, 0, 0, l, r);
    checks++;
    if (l !== 1 || r !== 32'h0) begin
      errors++;
      $display("FAIL illegal_const got lat=%0d res=%h exp lat=1 res=00000000", l, r);
    end
  endtask

  task automatic test_annul();
    int l; logic [31:0] r;
    run_op("annul", SRL, 5'd20, 32'hF000_0000, 0, 3, 0, l, r);
    checks++;
    if (l !== -1) begin
      errors++;
      $display("FAIL annul_noready got first_ready=%0d exp never", l);
    end
    run_op("after_annul", SRL, 5'd20, 32'hF000_0000, 0, 0, 0, l, r);
    checks++;
    if (l !== 6 || r !== 32'h0000_0F00) begin
      errors++;
      $display("FAIL after_annul_const got lat=%0d res=%h exp lat=6 res=00000f00", l, r);
    end
    // start together with annul in IDLE is ignored.
    start = 1'b1; annul = 1'b1; aluop = SLL; shamt = 5'd3; data = $urandom;
    repeat (2) begin
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (stl[i] !== 1'b0 || rdy[i] !== 1'b0) begin
          errors++;
          $display("FAIL annul_idle step=%0d got stall=%b ready=%b exp 0/0", step_of(i), stl[i], rdy[i]);
        end
      end
      @(negedge clk);
    end
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    check_idle("annul_idle_end");
  endtask

  task automatic test_reset_mid();
    int l; logic [31:0] r;
    run_op("rst_mid", SLL, 5'd17, $urandom, 0, 2, 1, l, r);
    checks++;
    if (l !== -1) begin
      errors++;
      $display("FAIL rst_mid_noready got first_ready=%0d exp never", l);
    end
  endtask

  task automatic test_held_start();
    int l; logic [31:0] r;
    run_op("held", SRA, 5'd9, 32'h8765_4321, 3, 0, 0, l, r);
    checks++;
    if (l !== 4 || r !== 32'hFFC3_B2A1) begin
      errors++;
      $display("FAIL held_const got lat=%0d res=%h exp lat=4 res=ffc3b2a1", l, r);
    end
  endtask

  task automatic rand_op(output logic [7:0] op);
    case ($urandom_range(0, 6))
      0, 1:    op = SLL;
      2, 3:    op = SRL;
      4, 5:    op = SRA;
      default: begin
        op = 8'($urandom);
        if (is_legal(op)) op = 8'hFF;
      end
    endcase
  endtask

  task automatic test_back_to_back();
    int l; logic [31:0] r; logic [7:0] op;
    for (int n = 0; n < 3; n++) begin
      rand_op(op);
      run_op("b2b", op, 5'($urandom), $urandom, 0, 0, 0, l, r);
    end
  endtask

  task automatic test_random_sweep();
    int l; logic [31:0] r; logic [7:0] op;
    for (int n = 0; n < 40; n++) begin
      rand_op(op);
      run_op("sweep", op, 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 2), 0, 0, l, r);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; annul = 1'b0; aluop = 8'h0; shamt = 5'd0; data = 32'h0;
    @(negedge clk);
    test_reset();
    test_sll();
    test_sra_srl();
    test_zero_illegal();
    test_annul();
    test_reset_mid();
    test_held_start();
    test_back_to_back();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
